// File: rtl/ivector_heard_serializer.sv
// Buffers IVector heard(meth, v) indications in a small FIFO and streams each
// one as a three-word message (header, meth, v) to the indication transport.
module ivector_heard_serializer #(
  parameter int          DEPTH  = 4,
  parameter logic [15:0] MSG_ID = 16'h0001
) (
  input  logic                   CLK,
  input  logic                   nRST,
  input  logic                   heard__ENA,
  input  logic [31:0]            heard_meth,
  input  logic [31:0]            heard_v,
  output logic                   heard__RDY,
  output logic                   msg__ENA,
  output logic [31:0]            msg_data,
  input  logic                   msg__RDY,
  output logic [15:0]            msg_count,
  output logic [$clog2(DEPTH):0] fifo_level
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {HDR, MET, VAL} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [15:0]     msg_count_q, msg_count_d;
  logic [31:0]     meth_q [DEPTH];
  logic [31:0]     v_q    [DEPTH];

  logic push, xfer, pop;

  // Flow control looks only at registered occupancy: a pop in the same
  // cycle never opens a slot for a push while full.
  assign heard__RDY = (level_q != LW'(DEPTH));
  assign msg__ENA   = (level_q != '0);
  assign push       = heard__ENA && heard__RDY;
  assign xfer       = msg__ENA && msg__RDY;
  assign pop        = xfer && (state_q == VAL);
  assign msg_count  = msg_count_q;
  assign fifo_level = level_q;

  always_comb begin
    msg_data = '0;
    if (msg__ENA) begin
      case (state_q)
        HDR:     msg_data = {MSG_ID, 16'd2};
        MET:     msg_data = meth_q[rd_ptr_q];
        VAL:     msg_data = v_q[rd_ptr_q];
        default: msg_data = '0;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    msg_count_d = msg_count_q;
    if (xfer) begin
      case (state_q)
        HDR:     state_d = MET;
        MET:     state_d = VAL;
        VAL:     state_d = HDR;
        default: state_d = HDR;
      endcase
    end
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d    = rd_ptr_q + 1'b1;
      msg_count_d = msg_count_q + 16'd1;
    end
    if (push && !pop)      level_d = level_q + LW'(1);
    else if (pop && !push) level_d = level_q - LW'(1);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= HDR;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      msg_count_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      msg_count_q <= msg_count_d;
    end
  end

  // Payload storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge CLK) begin
    if (push) begin
      meth_q[wr_ptr_q] <= heard_meth;
      v_q[wr_ptr_q]    <= heard_v;
    end
  end
endmodule

// File: tb/tb_ivector_heard_serializer.sv
// Directed and table-driven bench for ivector_heard_serializer with a word
// scoreboard for the backpressure and random-traffic sequences.
module tb_ivector_heard_serializer;
  logic        CLK = 1'b0;
  logic        nRST;
  logic        heard__ENA;
  logic [31:0] heard_meth, heard_v;
  logic        heard__RDY, msg__ENA, msg__RDY;
  logic [31:0] msg_data;
  logic [15:0] msg_count;
  logic [2:0]  fifo_level;

  localparam logic [31:0] HDRW = 32'h0001_0002;

  ivector_heard_serializer #(.DEPTH(4), .MSG_ID(16'h0001)) dut (
    .CLK(CLK), .nRST(nRST), .heard__ENA(heard__ENA), .heard_meth(heard_meth),
    .heard_v(heard_v), .heard__RDY(heard__RDY), .msg__ENA(msg__ENA),
    .msg_data(msg_data), .msg__RDY(msg__RDY), .msg_count(msg_count),
    .fifo_level(fifo_level)
  );

  always #5 CLK = ~CLK;

  int cmp   = 0;
  int fails = 0;
  logic mon_en = 1'b0;
  logic [31:0] exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] m, input logic [31:0] v);
    exp_q.push_back(HDRW);
    exp_q.push_back(m);
    exp_q.push_back(v);
  endtask

  // Word scoreboard: inputs settle at negedge, transfer happens at next posedge.
  always @(negedge CLK) begin
    #2;
    if (mon_en && msg__ENA && msg__RDY) begin
      if (exp_q.size() == 0) chk("unexpected_word", msg_data, 32'hDEAD_BEEF);
      else chk("stream_word", msg_data, exp_q.pop_front());
    end
  end

  always @(posedge CLK) begin
    if (nRST && heard__ENA && !heard__RDY) begin
      fails++;
      $display("FAIL push_while_full: heard__ENA=1 with heard__RDY=0");
    end
  end

  typedef struct {
    logic        ena;
    logic [31:0] meth, v;
    logic        rdy;
    logic        e_ena;
    logic [31:0] e_data;
    logic        e_hrdy;
    logic [2:0]  e_lvl;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t tv [23];

  initial begin
    // single message, then fill with backpressure and drain
    tv[0]  = '{1, 32'h5,  32'hA5A5, 1, 0, 32'h0,     1, 0, 0};
    tv[1]  = '{0, 32'h0,  32'h0,    1, 1, HDRW,      1, 1, 0};
    tv[2]  = '{0, 32'h0,  32'h0,    1, 1, 32'h5,     1, 1, 0};
    tv[3]  = '{0, 32'h0,  32'h0,    1, 1, 32'hA5A5,  1, 1, 0};
    tv[4]  = '{0, 32'h0,  32'h0,    0, 0, 32'h0,     1, 0, 1};
    tv[5]  = '{1, 32'd1,  32'd10,   0, 0, 32'h0,     1, 0, 1};
    tv[6]  = '{1, 32'd2,  32'd11,   0, 1, HDRW,      1, 1, 1};
    tv[7]  = '{1, 32'd3,  32'd12,   0, 1, HDRW,      1, 2, 1};
    tv[8]  = '{1, 32'd4,  32'd13,   0, 1, HDRW,      1, 3, 1};
    tv[9]  = '{0, 32'h0,  32'h0,    0, 1, HDRW,      0, 4, 1};
    tv[10] = '{0, 32'h0,  32'h0,    1, 1, HDRW,      0, 4, 1};
    tv[11] = '{0, 32'h0,  32'h0,    1, 1, 32'd1,     0, 4, 1};
    tv[12] = '{0, 32'h0,  32'h0,    1, 1, 32'd10,    0, 4, 1};
    tv[13] = '{0, 32'h0,  32'h0,    1, 1, HDRW,      1, 3, 2};
    tv[14] = '{0, 32'h0,  32'h0,    1, 1, 32'd2,     1, 3, 2};
    tv[15] = '{0, 32'h0,  32'h0,    1, 1, 32'd11,    1, 3, 2};
    tv[16] = '{0, 32'h0,  32'h0,    1, 1, HDRW,      1, 2, 3};
    tv[17] = '{0, 32'h0,  32'h0,    1, 1, 32'd3,     1, 2, 3};
    tv[18] = '{0, 32'h0,  32'h0,    1, 1, 32'd12,    1, 2, 3};
    tv[19] = '{0, 32'h0,  32'h0,    1, 1, HDRW,      1, 1, 4};
    tv[20] = '{0, 32'h0,  32'h0,    1, 1, 32'd4,     1, 1, 4};
    tv[21] = '{0, 32'h0,  32'h0,    1, 1, 32'd13,    1, 1, 4};
    tv[22] = '{0, 32'h0,  32'h0,    1, 0, 32'h0,     1, 0, 5};

    nRST = 1'b0; heard__ENA = 1'b0; heard_meth = '0; heard_v = '0; msg__RDY = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_ena",   32'(msg__ENA),   32'd0);
    chk("rst_data",  msg_data,        32'd0);
    chk("rst_cnt",   32'(msg_count),  32'd0);
    chk("rst_lvl",   32'(fifo_level), 32'd0);
    @(negedge CLK);
    nRST = 1'b1;

    for (int i = 0; i < 23; i++) begin
      @(negedge CLK);
      heard__ENA = tv[i].ena; heard_meth = tv[i].meth; heard_v = tv[i].v; msg__RDY = tv[i].rdy;
      #1;
      chk($sformatf("vec%0d_ena", i),  32'(msg__ENA),   32'(tv[i].e_ena));
      chk($sformatf("vec%0d_data", i), msg_data,        tv[i].e_data);
      chk($sformatf("vec%0d_hrdy", i), 32'(heard__RDY), 32'(tv[i].e_hrdy));
      chk($sformatf("vec%0d_lvl", i),  32'(fifo_level), 32'(tv[i].e_lvl));
      chk($sformatf("vec%0d_cnt", i),  32'(msg_count),  32'(tv[i].e_cnt));
    end

    // full FIFO while the head's last word transfers: no same-cycle bypass
    mon_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      heard__ENA = 1'b1; heard_meth = 32'd20 + k; heard_v = 32'd30 + k; msg__RDY = 1'b0;
      push_exp(32'd20 + k, 32'd30 + k);
    end
    @(negedge CLK); heard__ENA = 1'b0; #1;
    chk("full_lvl",  32'(fifo_level), 32'd4);
    chk("full_hrdy", 32'(heard__RDY), 32'd0);
    @(negedge CLK); msg__RDY = 1'b1;
    @(negedge CLK);
    @(negedge CLK); #1;
    chk("val_data", msg_data, 32'd30);
    chk("val_hrdy_nobypass", 32'(heard__RDY), 32'd0);
    @(negedge CLK); #1;
    chk("after_pop_hrdy", 32'(heard__RDY), 32'd1);
    chk("after_pop_lvl",  32'(fifo_level), 32'd3);
    heard__ENA = 1'b1; heard_meth = 32'd24; heard_v = 32'd34;
    push_exp(32'd24, 32'd34);
    @(negedge CLK); heard__ENA = 1'b0; #1;
    chk("refill_lvl", 32'(fifo_level), 32'd4);
    begin
      int t = 0;
      while ((exp_q.size() != 0 || fifo_level != 0) && t < 100) begin
        @(negedge CLK); t++;
      end
      if (t >= 100) chk("drain_timeout", 32'(t), 32'd0);
    end
    #1;
    chk("t3_cnt", 32'(msg_count), 32'd10);

    // random backpressure with 100 random messages
    begin
      int n = 0;
      int t = 0;
      logic done = 1'b0;
      while (!done && t < 3000) begin
        @(negedge CLK); t++;
        msg__RDY = 1'($urandom_range(0, 1));
        if (n < 100 && heard__RDY && $urandom_range(0, 1) == 1) begin
          heard__ENA = 1'b1; heard_meth = $urandom; heard_v = $urandom;
          push_exp(heard_meth, heard_v);
          n++;
        end else begin
          heard__ENA = 1'b0;
        end
        if (n == 100 && exp_q.size() == 0 && fifo_level == 0) done = 1'b1;
      end
      heard__ENA = 1'b0;
      if (!done) chk("rand_timeout", 32'(t), 32'd0);
    end
    #1;
    chk("t4_cnt", 32'(msg_count), 32'd110);

    // reset in the middle of a message with two entries queued
    mon_en = 1'b0; exp_q.delete();
    @(negedge CLK); heard__ENA = 1'b1; heard_meth = 32'd40; heard_v = 32'd50; msg__RDY = 1'b0;
    @(negedge CLK); heard_meth = 32'd41; heard_v = 32'd51;
    @(negedge CLK); heard__ENA = 1'b0; msg__RDY = 1'b1;
    @(negedge CLK); msg__RDY = 1'b0; #1;
    chk("pre_rst_met", msg_data, 32'd40);
    chk("pre_rst_lvl", 32'(fifo_level), 32'd2);
    nRST = 1'b0; #1;
    chk("mid_rst_ena",  32'(msg__ENA),   32'd0);
    chk("mid_rst_lvl",  32'(fifo_level), 32'd0);
    chk("mid_rst_data", msg_data,        32'd0);
    @(negedge CLK); nRST = 1'b1;
    @(negedge CLK); heard__ENA = 1'b1; heard_meth = 32'd7; heard_v = 32'd9; msg__RDY = 1'b1;
    @(negedge CLK); heard__ENA = 1'b0; #1;
    chk("post_rst_hdr", msg_data, HDRW);
    @(negedge CLK); #1; chk("post_rst_meth", msg_data, 32'd7);
    @(negedge CLK); #1; chk("post_rst_v",    msg_data, 32'd9);
    @(negedge CLK); #1;
    chk("post_rst_lvl", 32'(fifo_level), 32'd0);
    chk("post_rst_cnt", 32'(msg_count),  32'd1);

    // message counter wrap
    msg__RDY = 1'b0;
    force dut.msg_count_q = 16'hFFFF;
    @(negedge CLK);
    @(negedge CLK);
    release dut.msg_count_q;
    #1;
    chk("preload_cnt", 32'(msg_count), 32'h0000_FFFF);
    @(negedge CLK); heard__ENA = 1'b1; heard_meth = 32'd1; heard_v = 32'd2; msg__RDY = 1'b1;
    @(negedge CLK); heard__ENA = 1'b0;
    repeat (3) @(negedge CLK);
    #1;
    chk("wrap_cnt", 32'(msg_count),  32'd0);
    chk("wrap_lvl", 32'(fifo_level), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
